// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: symbol/dp/blink inputs from game logic, pin outputs to the board.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [5*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output num, dp_in, load, blink_mask,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  num, dp_in, load, blink_mask,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with anti-ghost blanking, per-digit blink
// and double-buffered symbol loading that only takes effect at frame boundaries.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned BLANK_CYCLES  = 500,
    parameter int unsigned BLINK_FRAMES  = 50,
    parameter bit          INVERT_SEG    = 1'b0,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [4:0]            SYM_BLANK = 5'd31;
    localparam logic [6:0]            SEG_OFF   = INVERT_SEG ? 7'h00 : 7'h7F;
    localparam logic                  DP_OFF    = ~INVERT_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;
    logic                  pending;
    logic                  wrapped;
    logic [4:0]            active [NUM_DIGITS];
    logic [4:0]            shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] sh_dp;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    logic                  slot_end_c;
    logic                  frame_end_c;
    logic [6:0]            seg_c;
    logic                  dp_c;
    logic [NUM_DIGITS-1:0] an_hot_c;
    logic [NUM_DIGITS-1:0] an_c;

    // Active-low segment pattern, bit6 = a .. bit0 = g
    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'b0000001;
            5'd1:    decode = 7'b1001111;
            5'd2:    decode = 7'b0010010;
            5'd3:    decode = 7'b0000110;
            5'd4:    decode = 7'b1001100;
            5'd5:    decode = 7'b0100100;
            5'd6:    decode = 7'b0100000;
            5'd7:    decode = 7'b0001111;
            5'd8:    decode = 7'b0000000;
            5'd9:    decode = 7'b0000100;
            5'd10:   decode = 7'b1000111;
            5'd12:   decode = 7'b1111000;
            5'd13:   decode = 7'b0001000;
            5'd15:   decode = 7'b1111001;
            5'd16:   decode = 7'b1001000;
            5'd17:   decode = 7'b0110000;
            5'd18:   decode = 7'b0110001;
            5'd20:   decode = 7'b0100100;
            5'd21:   decode = 7'b0011000;
            5'd22:   decode = 7'b1110111;
            5'd23:   decode = 7'b0110111;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign slot_end_c  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign frame_end_c = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));

    // Next pin values for the current slot; anode held off during blanking and blink-off phase
    always_comb begin
        seg_c    = decode(active[idx]) ^ {7{INVERT_SEG}};
        dp_c     = ~act_dp[idx] ^ INVERT_SEG;
        an_hot_c = '0;
        if ((slot_cnt >= SLOT_W'(BLANK_CYCLES)) && !(blink_phase && bus.blink_mask[idx]))
            an_hot_c[idx] = 1'b1;
        an_c = AN_ACTIVE_LOW ? ~an_hot_c : an_hot_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            idx          <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            pending      <= 1'b0;
            wrapped      <= 1'b0;
            act_dp       <= '0;
            sh_dp        <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active[i] <= SYM_BLANK;
                shadow[i] <= SYM_BLANK;
            end
        end else begin
            slot_cnt <= slot_end_c ? '0 : slot_cnt + SLOT_W'(1);
            if (slot_end_c)
                idx <= frame_end_c ? '0 : idx + IDX_W'(1);

            if (frame_end_c) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end

            if (bus.load) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    shadow[i] <= bus.num[5*i +: 5];
                sh_dp <= bus.dp_in;
            end

            // Active only changes on the frame boundary; a coincident load bypasses the shadow
            if (frame_end_c && bus.load) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    active[i] <= bus.num[5*i +: 5];
                act_dp  <= bus.dp_in;
                pending <= 1'b0;
            end else if (frame_end_c && pending) begin
                active  <= shadow;
                act_dp  <= sh_dp;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end

            wrapped      <= frame_end_c;
            frame_done_q <= wrapped;
            seg_q        <= seg_c;
            dp_q         <= dp_c;
            an_q         <= an_c;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule
